// File: rtl/conv_enc_213.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_enc_213 : rate-1/2 K=4 convolutional encoder (G0=1111, G1=1101)      |
// |                framed with 3 zero tail bits, valid/ready on both sides.  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module conv_enc_213 #(
  parameter int FRAME_LEN = 16,
  parameter int M         = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_last,
  output logic [2:0] enc_state,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT  = 8'(FRAME_LEN - 1);
  localparam logic [1:0] LAST_TAIL = 2'(M - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] tcnt_q, tcnt_d;
  logic [2:0] sr_q, sr_d;
  logic [1:0] sym_out_q, sym_out_d;
  logic       sym_valid_q, sym_valid_d;
  logic       sym_last_q, sym_last_d;

  logic load_ok;
  logic accept;
  logic load;
  logic u;
  logic last;

  always_comb begin
    load_ok     = !sym_valid_q || sym_ready;
    din_ready   = reset && (state_q != TAIL) && load_ok;
    accept      = din_valid && din_ready;

    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    sr_d        = sr_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    load        = 1'b0;
    u           = 1'b0;
    last        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          u    = din;
          if (FRAME_LEN == 1) begin
            state_d = TAIL;
          end else begin
            state_d = DATA;
            cnt_d   = 8'd1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          load = 1'b1;
          u    = din;
          if (cnt_q == LAST_CNT) begin
            state_d = TAIL;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      TAIL: begin
        // Tail bits are zeros pushed in without touching the input side
        if (load_ok) begin
          load = 1'b1;
          if (tcnt_q == LAST_TAIL) begin
            last    = 1'b1;
            state_d = IDLE;
            tcnt_d  = 2'd0;
          end else begin
            tcnt_d = tcnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // sr_q is {sr2,sr1,sr0}
    if (load) begin
      sym_out_d   = {u ^ sr_q[0] ^ sr_q[1] ^ sr_q[2], u ^ sr_q[0] ^ sr_q[2]};
      sym_valid_d = 1'b1;
      sym_last_d  = last;
      sr_d        = {sr_q[1], sr_q[0], u};
    end else if (load_ok) begin
      sym_valid_d = 1'b0;
      sym_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      tcnt_q      <= 2'd0;
      sr_q        <= 3'd0;
      sym_out_q   <= 2'd0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      sr_q        <= sr_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
    end
  end

  assign sym_out   = sym_out_q;
  assign sym_valid = sym_valid_q;
  assign sym_last  = sym_last_q;
  assign enc_state = sr_q;
  assign busy      = reset && ((state_q != IDLE) || sym_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_conv_enc_213.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_enc_213 : randomized self-checking bench for conv_enc_213        |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_conv_enc_213;

  localparam logic [3:0] G0 = 4'b1111;
  localparam logic [3:0] G1 = 4'b1101;

  logic clk = 1'b0;
  logic rst_n, din, din_valid, sym_ready, sel;
  logic       a_din_ready, a_sym_valid, a_sym_last, a_busy;
  logic [1:0] a_sym_out;
  logic [2:0] a_enc_state;
  logic       b_din_ready, b_sym_valid, b_sym_last, b_busy;
  logic [1:0] b_sym_out;
  logic [2:0] b_enc_state;
  logic       m_din_ready, m_sym_valid, m_sym_last, m_busy;
  logic [1:0] m_sym_out;
  logic [2:0] m_enc_state;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_low;
  int drv_cyc;
  bit         tx_q[$];
  bit         sent[$];
  logic [1:0] rx_sym[$];
  bit         rx_last[$];
  logic [1:0] exp_sym[$];
  bit         exp_last[$];
  logic [3:0] frames[20];

  always #5 clk = ~clk;

  conv_enc_213 #(.FRAME_LEN(4), .M(3)) u_dut_a (
    .clock(clk), .reset(rst_n), .din(din), .din_valid(din_valid && !sel),
    .din_ready(a_din_ready), .sym_out(a_sym_out), .sym_valid(a_sym_valid),
    .sym_ready(sym_ready), .sym_last(a_sym_last), .enc_state(a_enc_state),
    .busy(a_busy)
  );

  conv_enc_213 #(.FRAME_LEN(1), .M(3)) u_dut_b (
    .clock(clk), .reset(rst_n), .din(din), .din_valid(din_valid && sel),
    .din_ready(b_din_ready), .sym_out(b_sym_out), .sym_valid(b_sym_valid),
    .sym_ready(sym_ready), .sym_last(b_sym_last), .enc_state(b_enc_state),
    .busy(b_busy)
  );

  assign m_din_ready = sel ? b_din_ready : a_din_ready;
  assign m_sym_out   = sel ? b_sym_out   : a_sym_out;
  assign m_sym_valid = sel ? b_sym_valid : a_sym_valid;
  assign m_sym_last  = sel ? b_sym_last  : a_sym_last;
  assign m_enc_state = sel ? b_enc_state : a_enc_state;
  assign m_busy      = sel ? b_busy      : a_busy;

  // Inputs change 1 time unit after posedge, so negedge sees settled handshakes
  always @(negedge clk) begin
    if (rst_n && m_sym_valid && sym_ready) begin
      rx_sym.push_back(m_sym_out);
      rx_last.push_back(m_sym_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Symbol n of a frame: convolution of the zero-padded data with each generator
  function automatic logic [1:0] conv_sym(input logic [7:0] frm, input int fl, input int n);
    logic c0, c1, x;
    int   idx;
    c0 = 1'b0;
    c1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      idx = n - j;
      x   = (idx >= 0 && idx < fl) ? frm[idx[2:0]] : 1'b0;
      if (G0[3-j]) c0 ^= x;
      if (G1[3-j]) c1 ^= x;
    end
    return {c0, c1};
  endfunction

  task automatic build_model(input int fl);
    logic [7:0] frm;
    exp_sym.delete();
    exp_last.delete();
    for (int f = 0; f < sent.size() / fl; f++) begin
      frm = '0;
      for (int k = 0; k < fl; k++) frm[k] = sent[f*fl + k];
      for (int n = 0; n < fl + 3; n++) begin
        exp_sym.push_back(conv_sym(frm, fl, n));
        exp_last.push_back(n == fl + 2);
      end
    end
  endtask

  task automatic check_rx(input string tag);
    int n;
    chk({tag, "_cnt"}, rx_sym.size(), exp_sym.size());
    n = (rx_sym.size() < exp_sym.size()) ? rx_sym.size() : exp_sym.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), rx_sym[i], exp_sym[i]);
      chk($sformatf("%s_last%0d", tag, i), rx_last[i], exp_last[i]);
    end
    chk({tag, "_state"}, m_enc_state, 3'd0);
  endtask

  task automatic load_bits(input bit b);
    tx_q.push_back(b);
    sent.push_back(b);
  endtask

  task automatic clear_all();
    tx_q.delete();
    sent.delete();
    rx_sym.delete();
    rx_last.delete();
  endtask

  // Runs until tx_q is drained and the DUT is idle; optionally stalls the
  // output for 5 cycles once stall_at symbols have been transferred.
  task automatic drive(input bit rnd, input int stall_at, input logic [1:0] st_sym,
                       input logic [2:0] st_state, input int max_cyc);
    int k = 0;
    int st_left;
    bit stalled;
    st_left = (stall_at >= 0) ? 5 : 0;
    rdy_low = 0;
    while ((tx_q.size() != 0 || m_busy) && k < max_cyc) begin
      din_valid = (tx_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      din       = (tx_q.size() != 0) ? tx_q[0] : 1'b0;
      stalled   = (st_left > 0) && (rx_sym.size() == stall_at) && m_sym_valid;
      if (stalled) begin
        sym_ready = 1'b0;
        st_left--;
      end else begin
        sym_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      @(negedge clk);
      if (stalled) begin
        chk("stall_sym", m_sym_out, st_sym);
        chk("stall_last", m_sym_last, 1'b0);
        chk("stall_state", m_enc_state, st_state);
        chk("stall_rdy", m_din_ready, 1'b0);
      end
      if (!m_din_ready) rdy_low++;
      if (din_valid && m_din_ready) void'(tx_q.pop_front());
      @(posedge clk);
      #1;
      k++;
    end
    drv_cyc   = k;
    din_valid = 1'b0;
    sym_ready = 1'b1;
    chk("drive_done", (k < max_cyc), 1'b1);
  endtask

  task automatic set_ref42();
    exp_sym  = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  endtask

  initial begin
    int best, bestd, d, nfr, any_last;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sym_ready = 1'b1; sel = 1'b0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", a_din_ready, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_valid", a_sym_valid, 1'b0);
    chk("rst_last", a_sym_last, 1'b0);
    chk("rst_state", a_enc_state, 3'd0);
    chk("rst_b_valid", b_sym_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("idle_rdy", a_din_ready, 1'b1);
    chk("idle_busy", a_busy, 1'b0);
    @(posedge clk);
    #1;

    // Directed reference frame 1,0,1,1
    clear_all();
    load_bits(1); load_bits(0); load_bits(1); load_bits(1);
    drive(1'b0, -1, 2'b00, 3'b000, 100);
    set_ref42();
    check_rx("ref");

    // Stall on the second tail symbol
    clear_all();
    load_bits(1); load_bits(0); load_bits(1); load_bits(1);
    drive(1'b0, 5, 2'b01, 3'b100, 100);
    set_ref42();
    check_rx("stall");

    // Two back-to-back frames, continuous valid and ready
    clear_all();
    repeat (8) load_bits(1'($urandom_range(0, 1)));
    drive(1'b0, -1, 2'b00, 3'b000, 100);
    build_model(4);
    check_rx("b2b");
    chk("b2b_rdylow", rdy_low, 6);
    chk("b2b_cycles", drv_cyc, 15);

    // Reset after the second data bit
    clear_all();
    sym_ready = 1'b1; din_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    din = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; din = 1'b1;
    @(posedge clk); #1;
    chk("mrst_valid", a_sym_valid, 1'b0);
    chk("mrst_state", a_enc_state, 3'd0);
    chk("mrst_rdy", a_din_ready, 1'b0);
    chk("mrst_busy", a_busy, 1'b0);
    rst_n = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    any_last = 0;
    foreach (rx_last[i]) any_last += int'(rx_last[i]);
    chk("mrst_nolast", any_last, 0);
    clear_all();
    load_bits(1); load_bits(0); load_bits(1); load_bits(1);
    drive(1'b0, -1, 2'b00, 3'b000, 100);
    set_ref42();
    check_rx("post_rst");

    // 20 random frames under random handshakes, decoded by exhaustive ML search
    clear_all();
    for (int f = 0; f < 20; f++) begin
      frames[f] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) load_bits(frames[f][k]);
    end
    drive(1'b1, -1, 2'b00, 3'b000, 3000);
    build_model(4);
    check_rx("rnd");
    nfr = rx_sym.size() / 7;
    for (int f = 0; f < nfr && f < 20; f++) begin
      best = 0; bestd = 1000;
      for (int c = 0; c < 16; c++) begin
        d = 0;
        for (int n = 0; n < 7; n++)
          d += $countones(rx_sym[f*7 + n] ^ conv_sym(8'(c), 4, n));
        if (d < bestd) begin bestd = d; best = c; end
      end
      chk($sformatf("vit_bits%0d", f), best, frames[f]);
      chk($sformatf("vit_dist%0d", f), bestd, 0);
    end

    // FRAME_LEN=1 instance
    sel = 1'b1;
    @(posedge clk); #1;
    clear_all();
    load_bits(1);
    drive(1'b0, -1, 2'b00, 3'b000, 100);
    exp_sym  = '{2'b11, 2'b11, 2'b10, 2'b11};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_rx("fl1");
    clear_all();
    repeat (3) load_bits(1'($urandom_range(0, 1)));
    drive(1'b1, -1, 2'b00, 3'b000, 500);
    build_model(1);
    check_rx("fl1_rnd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
